// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters using round-robin arbitration.
// Latency: an op accepted at edge T has its response valid from T+1 (one-entry response register).
// Backpressure: requesters are stalled while the response is held and unconsumed; a same-cycle drain re-accepts.
module alu_share_arbiter #(
  parameter int DATA_W   = 32,
  parameter int CTRL_W   = 4,
  parameter int MAX_CTRL = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // requester 0
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_src1_i,
  input  logic [DATA_W-1:0] req0_src2_i,
  input  logic [CTRL_W-1:0] req0_ctrl_i,
  // requester 1
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_src1_i,
  input  logic [DATA_W-1:0] req1_src2_i,
  input  logic [CTRL_W-1:0] req1_ctrl_i,
  // ALU side
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  // response
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_zero_o,
  output logic              rsp_id_o,
  output logic              rsp_err_o
);

  localparam logic [CTRL_W-1:0] MAX_CTRL_C = CTRL_W'(MAX_CTRL);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;
  logic   rr_ptr;
  logic   can_accept;
  logic   grant_id;
  logic   grant_vld;
  logic   sel;

  // Response slot is free when empty or when its current occupant leaves this cycle.
  // Readies are gated by reset so a requester never sees a handshake that reset discards.
  always_comb begin
    can_accept   = (state == EMPTY) || rsp_ready_i;
    grant_id     = (req0_valid_i && req1_valid_i) ? rr_ptr : req1_valid_i;
    grant_vld    = rst_i && can_accept && (req0_valid_i || req1_valid_i);
    req0_ready_o = grant_vld && !grant_id;
    req1_ready_o = grant_vld && grant_id;
  end

  // Steer the granted requester onto the ALU; with no grant, park on the pointer's requester.
  always_comb begin
    sel        = grant_vld ? grant_id : rr_ptr;
    alu_src1_o = sel ? req1_src1_i : req0_src1_i;
    alu_src2_o = sel ? req1_src2_i : req0_src2_i;
    alu_ctrl_o = sel ? req1_ctrl_i : req0_ctrl_i;
  end

  assign rsp_valid_o = (state == FULL);

  // Response register, occupancy FSM and round-robin pointer; data only changes on a transfer.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= EMPTY;
      rr_ptr       <= 1'b0;
      rsp_result_o <= '0;
      rsp_zero_o   <= 1'b0;
      rsp_id_o     <= 1'b0;
      rsp_err_o    <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (grant_vld) state <= FULL;
        end
        FULL: begin
          if (rsp_ready_i && !grant_vld) state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
      if (grant_vld) begin
        rsp_result_o <= alu_result_i;
        rsp_zero_o   <= alu_zero_i;
        rsp_id_o     <= grant_id;
        rsp_err_o    <= (alu_ctrl_o > MAX_CTRL_C);
        rr_ptr       <= ~grant_id;
      end
    end
  end

endmodule
